button_input_handler: RTL and testbench



---
 rtl/button_input_handler.sv | 53 +++++
 tb/tb_button_input_handler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/button_input_handler.sv
// Push-button conditioner: polarity stage, SYNC_STAGES-flop synchronizer, symmetric debounce filter.
// Define BUTTON_HANDLER_ACTIVE_LOW_EN for an active-low button_in; button_out stays active-high.
module button_input_handler #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_out
);

  localparam int CNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   raw;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_WIDTH-1:0]   cnt;

`ifdef BUTTON_HANDLER_ACTIVE_LOW_EN
  assign raw = ~button_in;
`else
  assign raw = button_in;
`endif

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // The count only advances while synced disagrees with the output, so any
  // bounce back to the current output level restarts the window from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      button_out <= 1'b0;
    end else if (synced == button_out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      button_out <= synced;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_button_input_handler.sv
// Bench for button_input_handler: two instances (DEBOUNCE_CYCLES 4 and 1) against a sliding-window model.
module tb_button_input_handler;

  localparam int S  = 2;
  localparam int D4 = 4;

`ifdef BUTTON_HANDLER_ACTIVE_LOW_EN
  localparam logic IDLE = 1'b1;
`else
  localparam logic IDLE = 1'b0;
`endif
  localparam logic PRESS = ~IDLE;

  logic clk = 1'b0;
  logic reset;
  logic button_in;
  logic out4;
  logic out1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_input_handler #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D4)) u_d4 (
    .clk(clk), .reset(reset), .button_in(button_in), .button_out(out4)
  );

  button_input_handler #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(1)) u_d1 (
    .clk(clk), .reset(reset), .button_in(button_in), .button_out(out1)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output takes level v at an edge when the D pressed-level samples
  // taken S..S+D-1 edges ago all equal v and differ from the current output.
  logic [S+D4-1:0] h4 = '0;
  logic [S:0]      h1 = '0;
  logic            m4 = 1'b0;
  logic            m1 = 1'b0;

  initial begin
    logic r;
    logic lvl;
    forever begin
      @(posedge clk);
      r   = reset;
      lvl = (button_in == PRESS);
      if (r) begin
        h4 = '0; h1 = '0; m4 = 1'b0; m1 = 1'b0;
      end else begin
        h4 = {h4[S+D4-2:0], lvl};
        h1 = {h1[S-1:0], lvl};
        if (h4[S+D4-1:S] == {D4{~m4}}) m4 = ~m4;
        if (h1[S] == ~m1) m1 = ~m1;
      end
      #1;
      check("model_d4", out4, m4);
      check("model_d1", out1, m1);
    end
  end

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset     = 1'b1;
    button_in = IDLE;
    wait_edges(3);
    check("reset_d4", out4, 1'b0);
    check("reset_d1", out1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_d4", out4, 1'b0);
    end

    // Clean press then release: D=4 switches on edge 6, D=1 on edge 3.
    button_in = PRESS;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check("press_d4", out4, logic'(e >= 6));
      check("press_d1", out1, logic'(e >= 3));
    end
    button_in = IDLE;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check("release_d4", out4, logic'(e < 6));
      check("release_d1", out1, logic'(e < 3));
    end

    // Bounce 1,0,1,1,0 then steady pressed.
    for (int i = 0; i < 5; i++) begin
      button_in = pat[i] ? PRESS : IDLE;
      @(negedge clk);
      check("bounce_d4", out4, 1'b0);
    end
    button_in = PRESS;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check("bounce_settle_d4", out4, logic'(e >= 6));
    end
    button_in = IDLE;
    wait_edges(10);
    check("released_d4", out4, 1'b0);

    // Reset lands on edge 4 of a count; count restarts after release.
    button_in = PRESS;
    wait_edges(3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_d4", out4, 1'b0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check("after_reset_d4", out4, logic'(e >= 6));
    end

    // Random bursts with occasional resets; the model process does the checking.
    for (int seg = 0; seg < 300; seg++) begin
      button_in = $urandom_range(0, 1) ? PRESS : IDLE;
      reset     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      reset = 1'b0;
      wait_edges($urandom_range(0, 9));
    end
    button_in = IDLE;
    wait_edges(12);
    check("final_idle_d4", out4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
